// File: rtl/rgb_hue_pwm.sv
// rgb_hue_pwm: three-channel PWM engine with hue wheel, breathe, static and off modes.
module rgb_hue_pwm #(
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 47,
    parameter int STEP_PERIODS = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [3*PWM_BITS-1:0] static_rgb,
    output logic                  RGB_R,
    output logic                  RGB_G,
    output logic                  RGB_B,
    output logic                  period_strobe,
    output logic [2:0]            hue_sector
);
    localparam int N  = PWM_BITS;
    localparam int PW = $clog2(PRESCALE + 1);
    localparam int SW = $clog2(STEP_PERIODS + 1);
    localparam logic [N-1:0] M = '1;
    localparam logic [N-1:0] Z = '0;
    localparam logic AL = (ACTIVE_LOW != 0);

    logic [PW-1:0]  presc_q, presc_d;
    logic [N-1:0]   pwm_q, pwm_d, ramp_q, ramp_d, b_q, b_d;
    logic [SW-1:0]  step_q, step_d;
    logic [2:0]     sec_q, sec_d, hsec_q, hsec_d, rgb_q, rgb_d;
    logic           dn_q, dn_d, stb_q, stb_d;
    logic [3*N-1:0] duty_q, duty_d, hue_duty, br_duty, nxt;
    logic [2*N-1:0] prod_r, prod_g, prod_b;
    logic           tick, pb, astep, hue_adv, br_adv;

    always_comb begin
        tick    = en && presc_q == PW'(PRESCALE - 1);
        pb      = tick && pwm_q == M;
        astep   = pb && step_q == SW'(STEP_PERIODS - 1);
        hue_adv = astep && mode == 2'd0;
        br_adv  = astep && mode == 2'd1;
        presc_d = !en ? presc_q : tick ? '0 : presc_q + 1'b1;
        pwm_d   = tick ? pwm_q + 1'b1 : pwm_q;
        step_d  = !pb ? step_q : astep ? '0 : step_q + 1'b1;
        ramp_d  = hue_adv ? ramp_q + 1'b1 : ramp_q;
        sec_d   = (hue_adv && ramp_q == M) ? (sec_q == 3'd5 ? 3'd0 : sec_q + 3'd1) : sec_q;
        // Breathe holds at each end for one step while the direction flips.
        b_d     = !br_adv ? b_q : dn_q ? (b_q == Z ? b_q : b_q - 1'b1) : (b_q == M ? b_q : b_q + 1'b1);
        dn_d    = !br_adv ? dn_q : dn_q ? (b_q != Z) : (b_q == M);
        case (sec_q)
            3'd0:    hue_duty = {M, ramp_q, Z};
            3'd1:    hue_duty = {M - ramp_q, M, Z};
            3'd2:    hue_duty = {Z, M, ramp_q};
            3'd3:    hue_duty = {Z, M, M - ramp_q};
            3'd4:    hue_duty = {ramp_q, Z, M};
            default: hue_duty = {M, Z, M - ramp_q};
        endcase
        prod_r  = {Z, static_rgb[3*N-1:2*N]} * {Z, b_q};
        prod_g  = {Z, static_rgb[2*N-1:N]} * {Z, b_q};
        prod_b  = {Z, static_rgb[N-1:0]} * {Z, b_q};
        br_duty = {prod_r[2*N-1:N], prod_g[2*N-1:N], prod_b[2*N-1:N]};
        nxt     = mode == 2'd0 ? hue_duty : mode == 2'd1 ? br_duty : mode == 2'd2 ? static_rgb : '0;
        duty_d  = pb ? nxt : duty_q;
        hsec_d  = pb ? sec_q : hsec_q;
        rgb_d   = en ? {pwm_q < duty_q[3*N-1:2*N], pwm_q < duty_q[2*N-1:N], pwm_q < duty_q[N-1:0]} ^ {3{AL}}
                     : {3{AL}};
        stb_d   = pb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pwm_q   <= '0;
            step_q  <= '0;
            ramp_q  <= '0;
            sec_q   <= '0;
            b_q     <= '0;
            dn_q    <= 1'b0;
            duty_q  <= '0;
            hsec_q  <= '0;
            rgb_q   <= {3{AL}};
            stb_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            step_q  <= step_d;
            ramp_q  <= ramp_d;
            sec_q   <= sec_d;
            b_q     <= b_d;
            dn_q    <= dn_d;
            duty_q  <= duty_d;
            hsec_q  <= hsec_d;
            rgb_q   <= rgb_d;
            stb_q   <= stb_d;
        end
    end

    assign {RGB_R, RGB_G, RGB_B} = rgb_q;
    assign period_strobe = stb_q;
    assign hue_sector    = hsec_q;
endmodule

// File: doc/rgb_hue_pwm.md
# rgb_hue_pwm

Parametrised three-channel PWM engine driving the on-board RGB LED pins (RGB_R/RGB_G/RGB_B) directly from `top`. It supersedes the fixed-interval colour cycler with:
- configurable PWM resolution, tick rate and animation speed;
- four run modes: hue wheel, breathing on a programmable colour, static colour, off;
- a period strobe;
- active-low/active-high output polarity.

## Interface
- PWM_BITS, 8: duty/PWM counter width N; PWM period = 2^N ticks.
- PRESCALE, 47: clocks per PWM tick; legal values ≥1.
- STEP_PERIODS, 4: PWM periods per animation step; legal values ≥1.
- ACTIVE_LOW, 1: 1 means the output is driven low when the channel is on (iCE40 current-sink driver).
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  run enable; 0 freezes all counters.
- mode  input  2  0 hue wheel, 1 breathe, 2 static, 3 off.
- static_rgb  input  3N  {R,G,B} duty values for modes 1/2; R occupies the MSBs.
- RGB_R, RGB_G, RGB_B  output  1  registered PWM outputs.
- period_strobe  output  1  one-cycle pulse at each PWM period boundary.
- hue_sector  output  3  current wheel sector, 0..5.

## Operation
**Reset values.** All counters are 0, the sector is 0, the breathe direction is up, and the duty latches are 0. RGB_x = ACTIVE_LOW (off), period_strobe = 0, hue_sector = 0.

**Prescaler.** presc counts 0..PRESCALE-1. tick is asserted when presc == PRESCALE-1 and en=1.

**PWM counter.** pwm_cnt (N bits) increments on tick and wraps 2^N-1 → 0.

**Period boundary (PB).** A PB is a tick with pwm_cnt == 2^N-1. At a PB:
- all three duty latches load the next-duty values;
- period_strobe pulses;
- the step counter advances.

mode and static_rgb are sampled only at a PB, so duty changes are glitch-free.

**Step.** The step counter counts PBs over 0..STEP_PERIODS-1. An animation step occurs at the PB where it equals STEP_PERIODS-1, and the counter then wraps.

**Hue wheel.** State is (sector, ramp r), with M = 2^N-1. Each step does r+1. When r == M: r←0 and sector+1, with 5 wrapping to 0. Next duties (R,G,B) by sector:
- 0: (M, r, 0)
- 1: (M-r, M, 0)
- 2: (0, M, r)
- 3: (0, M, M-r)
- 4: (r, 0, M)
- 5: (M, 0, M-r)

**Breathe.** Brightness b is N bits with a direction bit:
- Going up: b+1 per step; at b == M the direction flips down and b holds M for that step.
- Going down: b-1 per step; at b == 0 the direction flips up and b holds 0 for that step.

Each channel duty = (static_c × b) >> N. The product is 2N bits; the upper N bits are kept.

**Static.** Duties = static_rgb.

**Off.** Duties = 0.

**Animation state.** Hue and breathe state advance only while their mode is selected, and are retained across mode switches.

**Output compare.** A channel is on when pwm_cnt < duty_latch. Duty 0 means always off; duty M means on for M of 2^N ticks, so 100% is never reached. RGB_x = on XOR ACTIVE_LOW.

**Enable low.** en=0 holds presc, pwm_cnt, the step counter, and the hue/breathe state. The outputs are forced off on the next clock and period_strobe stays 0. When en returns to 1, operation resumes from the held state.

**Reset mid-period.** rst_n low immediately forces the reset values, independent of clk. On release, the first PB occurs PRESCALE×2^N clocks after the first clock edge.

## Timing
- Outputs are registered: the compare result appears 1 clk after the pwm_cnt value that produced it.
- period_strobe is high in the clock after the PB tick, the same cycle pwm_cnt reads 0. The new duty latches are valid in that cycle.
- hue_sector updates together with the duty latches.
- PWM period = PRESCALE × 2^N clocks. A full hue cycle = 6 × 2^N × STEP_PERIODS periods.
- A simultaneous mode change and PB is sampled at that PB, so the new mode's duties apply in the period starting there.

## Test plan
Unless stated otherwise: N=4, PRESCALE=2, STEP_PERIODS=1, ACTIVE_LOW=1; the period is 32 clk.
- **Reset:** hold rst_n=0 for 5 clk, then release with mode=2 and static_rgb=12'hF80.
  - Required: all outputs 1 and strobe 0 during reset.
  - First period: all outputs 1.
  - Second period: R low for 30 clk, G low for 16 clk, B always high.
- **Static duty sweep:** R duty 0, 1, 8, 15.
  - Required: RGB_R low for exactly 0, 2, 16, 30 clk per 32-clk period.
  - period_strobe interval is exactly 32 clk.
- **Hue wheel:** mode=0 from reset.
  - Required: sector 0 → 1 after 16 steps; duties (15,15,0) at r=15 of sector 0; sector 5 → 0 wrap after 96 steps.
  - Per-step duty triple matches the sector table.
- **Breathe:** mode=1, static_rgb=12'hF84.
  - Required: b sequence 0,1,…,15,15,14,…,0,0,1.
  - At b=8: duties (7,4,2).
- **Enable/mode boundary:**
  - Drop en mid-period for 10 clk: outputs go 1 next clk; the PB is delayed by exactly 10 clk.
  - Change mode 2→3 mid-period: the old duty persists until the PB, then all outputs are 1.
- **ACTIVE_LOW=0 with reset mid-period:** assert rst_n at pwm_cnt=5.
  - Required: outputs 0 immediately, without waiting for a clk edge.
  - Restart timing identical to the reset scenario, with polarity inverted.
